// File: rtl/div_sqrt_mvp_arbiter.sv
// rtl/div_sqrt_mvp_arbiter.sv - round-robin arbiter sharing one div_sqrt_mvp unit between NUM_REQ requesters
module div_sqrt_mvp_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     Clk_CI,
  input  logic                     Rst_RI,
  input  logic [NUM_REQ-1:0]       Req_valid_SI,
  output logic [NUM_REQ-1:0]       Req_ready_SO,
  input  logic [NUM_REQ-1:0]       Req_sqrt_SI,
  input  logic [NUM_REQ-1:0][63:0] Req_a_DI,
  input  logic [NUM_REQ-1:0][63:0] Req_b_DI,
  input  logic [NUM_REQ-1:0][2:0]  Req_rm_SI,
  input  logic [NUM_REQ-1:0][5:0]  Req_pc_SI,
  input  logic [NUM_REQ-1:0][1:0]  Req_fmt_SI,
  input  logic [NUM_REQ-1:0]       Req_kill_SI,
  output logic [NUM_REQ-1:0]       Rsp_valid_SO,
  input  logic [NUM_REQ-1:0]       Rsp_ready_SI,
  output logic [63:0]              Rsp_result_DO,
  output logic [4:0]               Rsp_fflags_SO,
  output logic                     Div_start_SO,
  output logic                     Sqrt_start_SO,
  output logic [63:0]              Operand_a_DO,
  output logic [63:0]              Operand_b_DO,
  output logic [2:0]               RM_SO,
  output logic [5:0]               Precision_ctl_SO,
  output logic [1:0]               Format_sel_SO,
  output logic                     Kill_SO,
  input  logic [63:0]              Result_DI,
  input  logic [4:0]               Fflags_SI,
  input  logic                     Ready_SI,
  input  logic                     Done_SI
);

  localparam int KW = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

  state_t           State_SP;
  logic [IDX_W-1:0] Own_D;
  logic [IDX_W-1:0] Ptr_D;
  logic             Sqrt_SP;

  logic [IDX_W-1:0] Grant_idx_D;
  logic             Found_S;
  logic [KW-1:0]    Cand_D;
  logic             Grant_S;
  logic             Kill_own_S;
  logic [IDX_W-1:0] Own_next_D;

  // Cyclic search starting at the pointer; the extra bit keeps Ptr+i from overflowing before the wrap.
  always_comb begin
    Grant_idx_D = '0;
    Found_S     = 1'b0;
    Cand_D      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      Cand_D = {1'b0, Ptr_D} + KW'(i);
      if (Cand_D >= KW'(NUM_REQ)) Cand_D = Cand_D - KW'(NUM_REQ);
      if (!Found_S && Req_valid_SI[Cand_D[IDX_W-1:0]]) begin
        Found_S     = 1'b1;
        Grant_idx_D = Cand_D[IDX_W-1:0];
      end
    end
  end

  assign Grant_S    = (State_SP == IDLE) && Found_S && Ready_SI && !Rst_RI;
  assign Kill_own_S = Req_kill_SI[Own_D];
  assign Own_next_D = (Own_D == IDX_W'(NUM_REQ - 1)) ? '0 : Own_D + IDX_W'(1);

  always_comb begin
    Req_ready_SO = '0;
    Rsp_valid_SO = '0;
    if (Grant_S) Req_ready_SO[Grant_idx_D] = 1'b1;
    if (State_SP == RESP) Rsp_valid_SO[Own_D] = 1'b1;
  end

  // An owner kill arriving in ISSUE swallows the start pulse of that same cycle.
  assign Div_start_SO  = (State_SP == ISSUE) && !Sqrt_SP && !Kill_own_S;
  assign Sqrt_start_SO = (State_SP == ISSUE) &&  Sqrt_SP && !Kill_own_S;

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      State_SP         <= IDLE;
      Own_D            <= '0;
      Ptr_D            <= '0;
      Sqrt_SP          <= 1'b0;
      Operand_a_DO     <= '0;
      Operand_b_DO     <= '0;
      RM_SO            <= '0;
      Precision_ctl_SO <= '0;
      Format_sel_SO    <= '0;
      Rsp_result_DO    <= '0;
      Rsp_fflags_SO    <= '0;
      Kill_SO          <= 1'b0;
    end else begin
      Kill_SO <= 1'b0;
      case (State_SP)
        IDLE: begin
          if (Grant_S) begin
            State_SP         <= ISSUE;
            Own_D            <= Grant_idx_D;
            Sqrt_SP          <= Req_sqrt_SI[Grant_idx_D];
            Operand_a_DO     <= Req_a_DI[Grant_idx_D];
            Operand_b_DO     <= Req_b_DI[Grant_idx_D];
            RM_SO            <= Req_rm_SI[Grant_idx_D];
            Precision_ctl_SO <= Req_pc_SI[Grant_idx_D];
            Format_sel_SO    <= Req_fmt_SI[Grant_idx_D];
          end
        end
        ISSUE: begin
          if (Kill_own_S) begin
            State_SP <= IDLE;
            Kill_SO  <= 1'b1;
            Ptr_D    <= Own_next_D;
          end else begin
            State_SP <= BUSY;
          end
        end
        BUSY: begin
          if (Kill_own_S) begin
            State_SP <= IDLE;
            Kill_SO  <= 1'b1;
            Ptr_D    <= Own_next_D;
          end else if (Done_SI) begin
            State_SP      <= RESP;
            Rsp_result_DO <= Result_DI;
            Rsp_fflags_SO <= Fflags_SI;
          end
        end
        RESP: begin
          if (Kill_own_S || Rsp_ready_SI[Own_D]) begin
            State_SP <= IDLE;
            Ptr_D    <= Own_next_D;
          end
        end
        default: State_SP <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sqrt_mvp_arbiter.sv
// tb/tb_div_sqrt_mvp_arbiter.sv - self-checking bench for div_sqrt_mvp_arbiter
module tb_div_sqrt_mvp_arbiter;
  localparam int N = 4;

  logic               Clk_CI = 1'b0;
  logic               Rst_RI;
  logic [N-1:0]       Req_valid_SI, Req_ready_SO, Req_sqrt_SI, Req_kill_SI;
  logic [N-1:0][63:0] Req_a_DI, Req_b_DI;
  logic [N-1:0][2:0]  Req_rm_SI;
  logic [N-1:0][5:0]  Req_pc_SI;
  logic [N-1:0][1:0]  Req_fmt_SI;
  logic [N-1:0]       Rsp_valid_SO, Rsp_ready_SI;
  logic [63:0]        Rsp_result_DO, Operand_a_DO, Operand_b_DO, Result_DI;
  logic [4:0]         Rsp_fflags_SO, Fflags_SI;
  logic               Div_start_SO, Sqrt_start_SO, Kill_SO, Ready_SI, Done_SI;
  logic [2:0]         RM_SO;
  logic [5:0]         Precision_ctl_SO;
  logic [1:0]         Format_sel_SO;

  div_sqrt_mvp_arbiter #(.NUM_REQ(N)) dut (
    .Clk_CI(Clk_CI), .Rst_RI(Rst_RI),
    .Req_valid_SI(Req_valid_SI), .Req_ready_SO(Req_ready_SO), .Req_sqrt_SI(Req_sqrt_SI),
    .Req_a_DI(Req_a_DI), .Req_b_DI(Req_b_DI), .Req_rm_SI(Req_rm_SI), .Req_pc_SI(Req_pc_SI),
    .Req_fmt_SI(Req_fmt_SI), .Req_kill_SI(Req_kill_SI),
    .Rsp_valid_SO(Rsp_valid_SO), .Rsp_ready_SI(Rsp_ready_SI),
    .Rsp_result_DO(Rsp_result_DO), .Rsp_fflags_SO(Rsp_fflags_SO),
    .Div_start_SO(Div_start_SO), .Sqrt_start_SO(Sqrt_start_SO),
    .Operand_a_DO(Operand_a_DO), .Operand_b_DO(Operand_b_DO), .RM_SO(RM_SO),
    .Precision_ctl_SO(Precision_ctl_SO), .Format_sel_SO(Format_sel_SO), .Kill_SO(Kill_SO),
    .Result_DI(Result_DI), .Fflags_SI(Fflags_SI), .Ready_SI(Ready_SI), .Done_SI(Done_SI)
  );

  always #5 Clk_CI = ~Clk_CI;

  typedef struct {
    logic [3:0]  add;
    int          ready_low;
    int          lat;
    int          hold;
    logic [63:0] res;
    logic [4:0]  ff;
    int          exp_g;
  } vec_t;

  vec_t       tbl [13];
  int         checks = 0;
  int         errors = 0;
  int         mptr = 0;
  logic [3:0] pend = '0;
  int         waited [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk_CI);
    #1;
  endtask

  function automatic int rr_pick(input logic [3:0] p, input int ptr);
    for (int k = 0; k < N; k++)
      if (p[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic do_op(input logic [3:0] add, input int rl, input int lat, input int hold,
                       input logic [63:0] res, input logic [4:0] ff, input int exp_g);
    logic [3:0] oh;
    int act_g;
    oh = 4'(1 << exp_g);
    pend = pend | add;
    Req_valid_SI = pend;
    Ready_SI = 1'b0;
    for (int k = 0; k < rl; k++) begin
      #1 chk("unit_busy_no_grant", 64'(Req_ready_SO), 64'(0));
      tick();
    end
    Ready_SI = 1'b1;
    #1 chk("grant", 64'(Req_ready_SO), 64'(oh));
    act_g = -1;
    for (int i = 0; i < N; i++) if (Req_ready_SO[i]) act_g = i;
    if (act_g >= 0) begin
      for (int i = 0; i < N; i++) if (pend[i] && i != act_g) waited[i]++;
      chk("fair_wait", 64'(waited[act_g] <= N - 1), 64'(1));
      waited[act_g] = 0;
    end
    tick();
    pend[exp_g] = 1'b0;
    Req_valid_SI = pend;
    #1;
    chk("div_start", 64'(Div_start_SO), 64'(!Req_sqrt_SI[exp_g]));
    chk("sqrt_start", 64'(Sqrt_start_SO), 64'(Req_sqrt_SI[exp_g]));
    chk("op_a", Operand_a_DO, Req_a_DI[exp_g]);
    chk("op_b", Operand_b_DO, Req_b_DI[exp_g]);
    chk("op_misc", 64'({RM_SO, Precision_ctl_SO, Format_sel_SO}),
        64'({Req_rm_SI[exp_g], Req_pc_SI[exp_g], Req_fmt_SI[exp_g]}));
    chk("issue_no_ready", 64'(Req_ready_SO), 64'(0));
    tick();
    chk("one_start", 64'({Div_start_SO, Sqrt_start_SO}), 64'(0));
    for (int k = 0; k < lat; k++) begin
      chk("busy_no_rsp", 64'(Rsp_valid_SO), 64'(0));
      tick();
    end
    Result_DI = res;
    Fflags_SI = ff;
    Done_SI = 1'b1;
    tick();
    Done_SI = 1'b0;
    Result_DI = {$urandom, $urandom};
    Fflags_SI = 5'($urandom);
    #1;
    chk("rsp_valid", 64'(Rsp_valid_SO), 64'(oh));
    chk("rsp_result", Rsp_result_DO, res);
    chk("rsp_fflags", 64'(Rsp_fflags_SO), 64'(ff));
    chk("rsp_no_start", 64'({Div_start_SO, Sqrt_start_SO}), 64'(0));
    Rsp_ready_SI = ~oh;
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("hold_valid", 64'(Rsp_valid_SO), 64'(oh));
      chk("hold_result", Rsp_result_DO, res);
      chk("hold_fflags", 64'(Rsp_fflags_SO), 64'(ff));
      chk("hold_no_grant", 64'(Req_ready_SO), 64'(0));
    end
    Rsp_ready_SI = oh;
    tick();
    Rsp_ready_SI = '0;
    mptr = (exp_g + 1) % N;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2000000 ns");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [3:0] add;
    int         pick;

    Rst_RI = 1'b1; Req_valid_SI = '0; Req_kill_SI = '0; Rsp_ready_SI = '0;
    Result_DI = '0; Fflags_SI = '0; Ready_SI = 1'b0; Done_SI = 1'b0;
    for (int i = 0; i < N; i++) begin
      Req_a_DI[i]   = 64'h4000000000000000 + (64'(i) << 32);
      Req_b_DI[i]   = 64'h3FF0000000000000 + 64'(i);
      Req_sqrt_SI[i] = i[0];
      Req_rm_SI[i]  = 3'(i);
      Req_pc_SI[i]  = 6'(i * 5);
      Req_fmt_SI[i] = 2'(i + 1);
      waited[i]     = 0;
    end

    tbl[0]  = '{4'b0001, 3, 2, 0,  64'h4000000000000000, 5'h00, 0};
    tbl[1]  = '{4'b1111, 0, 0, 1,  64'h3FF8000000000000, 5'h01, 1};
    tbl[2]  = '{4'b0000, 1, 3, 0,  64'h0123456789ABCDEF, 5'h10, 2};
    tbl[3]  = '{4'b0000, 0, 1, 2,  64'hFEDCBA9876543210, 5'h03, 3};
    tbl[4]  = '{4'b1110, 0, 0, 0,  64'h7FF0000000000000, 5'h08, 0};
    tbl[5]  = '{4'b0000, 0, 2, 0,  64'h0000000000000001, 5'h04, 1};
    tbl[6]  = '{4'b0000, 2, 1, 1,  64'hAAAA5555AAAA5555, 5'h1F, 2};
    tbl[7]  = '{4'b0000, 0, 0, 0,  64'h5555AAAA5555AAAA, 5'h02, 3};
    tbl[8]  = '{4'b1001, 0, 1, 0,  64'h8000000000000000, 5'h11, 0};
    tbl[9]  = '{4'b0000, 0, 0, 0,  64'h3FE0000000000000, 5'h00, 3};
    tbl[10] = '{4'b1100, 0, 2, 10, 64'hC000000000000000, 5'h05, 2};
    tbl[11] = '{4'b0001, 0, 0, 0,  64'h4008000000000000, 5'h01, 3};
    tbl[12] = '{4'b0000, 0, 0, 0,  64'h0000000000000000, 5'h00, 0};

    repeat (3) @(posedge Clk_CI);
    #1;
    chk("reset_ready", 64'(Req_ready_SO), 64'(0));
    chk("reset_rsp", 64'({Rsp_valid_SO, Rsp_fflags_SO}), 64'(0));
    chk("reset_starts", 64'({Div_start_SO, Sqrt_start_SO, Kill_SO}), 64'(0));
    chk("reset_op_a", Operand_a_DO, 64'(0));
    Rst_RI = 1'b0;
    tick();

    for (int v = 0; v < 13; v++)
      do_op(tbl[v].add, tbl[v].ready_low, tbl[v].lat, tbl[v].hold, tbl[v].res, tbl[v].ff, tbl[v].exp_g);

    // kill in flight: owner req1 in BUSY, req0 kill ignored, next grant to req2
    pend = 4'b0110; Req_valid_SI = pend; Ready_SI = 1'b1;
    #1 chk("k_grant1", 64'(Req_ready_SO), 64'(4'b0010));
    tick(); pend[1] = 1'b0; Req_valid_SI = pend;
    tick();
    Req_kill_SI = 4'b0001;
    tick(); Req_kill_SI = '0;
    #1;
    chk("k_nonowner_no_kill", 64'(Kill_SO), 64'(0));
    chk("k_nonowner_still_busy", 64'(Req_ready_SO), 64'(0));
    Req_kill_SI = 4'b0010;
    tick(); Req_kill_SI = '0;
    #1;
    chk("k_kill_pulse", 64'(Kill_SO), 64'(1));
    chk("k_no_rsp", 64'(Rsp_valid_SO), 64'(0));
    chk("k_next_grant2", 64'(Req_ready_SO), 64'(4'b0100));
    tick(); pend[2] = 1'b0; Req_valid_SI = pend;
    chk("k_kill_once", 64'(Kill_SO), 64'(0));
    chk("k_start2", 64'({Div_start_SO, Sqrt_start_SO}), 64'({!Req_sqrt_SI[2], Req_sqrt_SI[2]}));

    // kill and done collide in BUSY: no response
    tick();
    Done_SI = 1'b1; Result_DI = 64'hDEADBEEFDEADBEEF; Req_kill_SI = 4'b0100;
    tick();
    Done_SI = 1'b0; Req_kill_SI = '0;
    chk("c_kill_pulse", 64'(Kill_SO), 64'(1));
    for (int k = 0; k < 3; k++) begin
      chk("c_no_rsp", 64'(Rsp_valid_SO), 64'(0));
      tick();
    end

    // pointer at 3 wraps to req0, then reset while in RESP
    pend = 4'b0001; Req_valid_SI = pend;
    #1 chk("w_grant0", 64'(Req_ready_SO), 64'(4'b0001));
    tick(); pend = '0; Req_valid_SI = pend;
    tick();
    Done_SI = 1'b1; Result_DI = 64'h1234567812345678; Fflags_SI = 5'h1F;
    tick(); Done_SI = 1'b0;
    chk("r_in_resp", 64'(Rsp_valid_SO), 64'(4'b0001));
    Rst_RI = 1'b1;
    #1;
    chk("r_rsp_valid", 64'(Rsp_valid_SO), 64'(0));
    chk("r_rsp_data", Rsp_result_DO, 64'(0));
    chk("r_rsp_ff", 64'(Rsp_fflags_SO), 64'(0));
    chk("r_ops", Operand_a_DO | Operand_b_DO, 64'(0));
    chk("r_ctl", 64'({Div_start_SO, Sqrt_start_SO, Kill_SO, RM_SO, Precision_ctl_SO, Format_sel_SO}), 64'(0));
    tick();
    Rst_RI = 1'b0;
    tick();
    chk("r_no_kill", 64'(Kill_SO), 64'(0));
    for (int i = 0; i < N; i++) waited[i] = 0;
    mptr = 0;
    do_op(4'b1111, 0, 1, 0, 64'h3FF0000000000000, 5'h00, 0);

    // randomized traffic against the round-robin reference
    for (int op = 0; op < 40; op++) begin
      add = '0;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(1, 0) == 1) add[i] = 1'b1;
      end
      if ((pend | add) == 4'b0000) add[$urandom_range(N - 1, 0)] = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (add[i] && !pend[i]) begin
          Req_a_DI[i]    = {$urandom, $urandom};
          Req_b_DI[i]    = {$urandom, $urandom};
          Req_sqrt_SI[i] = 1'($urandom);
          Req_rm_SI[i]   = 3'($urandom);
          Req_pc_SI[i]   = 6'($urandom);
          Req_fmt_SI[i]  = 2'($urandom);
        end
      end
      pick = rr_pick(pend | add, mptr);
      do_op(add, $urandom_range(2, 0), $urandom_range(4, 0), $urandom_range(3, 0),
            {$urandom, $urandom}, 5'($urandom), pick);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
